barrier_controller: RTL and testbench

Sequences SYNC and EXIT across NUM_CORES execution cores that share one kernel launch.
- Each core's control unit raises a sync request when it decodes SYNC; the block stalls that core until every still-active core has arrived, then releases them all together.
- EXIT pulses retire a core from the active set.
- Sits between the per-core control units and the top-level launch/status logic; reports kernel completion and barrier watchdog errors.

---
 rtl/barrier_pkg.sv | 15 +
 rtl/barrier_watchdog.sv | 47 ++++
 rtl/barrier_controller.sv | 116 +++++++++++
 tb/tb_barrier_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/barrier_pkg.sv
// Shared types and defaults for the core barrier controller.
package barrier_pkg;

   localparam int unsigned NumCoresDflt     = 4;
   localparam int unsigned TimeoutWidthDflt = 16;
   localparam int unsigned CountWidth       = 8;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRun     = 2'd1,
      StRelease = 2'd2,
      StDone    = 2'd3
   } barrier_state_e;

endpackage

// File: rtl/barrier_watchdog.sv
// Barrier wait watchdog: saturating cycle counter, limit compare and sticky error flag.
module barrier_watchdog
   import barrier_pkg::*;
#(
   parameter int unsigned TIMEOUT_WIDTH = TimeoutWidthDflt
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic                     clear_i,
   input  logic                     inc_i,
   input  logic [TIMEOUT_WIDTH-1:0] limit_i,
   output logic                     err_o
);

   logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
   logic                     err_q, err_d;

   always_comb begin
      wd_d  = wd_q;
      err_d = err_q;
      if (start_i || clear_i) begin
         wd_d = '0;
      end else if (inc_i && (wd_q != '1)) begin
         wd_d = wd_q + 1'b1;
      end
      // A zero limit disables the flag; start clears it even if the compare hits.
      if (start_i) begin
         err_d = 1'b0;
      end else if ((limit_i != '0) && (wd_q == limit_i)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/barrier_controller.sv
// Stalls cores at SYNC until every active core arrives, releases them together, retires on EXIT.
module barrier_controller
   import barrier_pkg::*;
#(
   parameter int unsigned NUM_CORES     = NumCoresDflt,
   parameter int unsigned TIMEOUT_WIDTH = TimeoutWidthDflt
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic [NUM_CORES-1:0]     core_sync_req_i,
   input  logic [NUM_CORES-1:0]     core_exit_i,
   input  logic [TIMEOUT_WIDTH-1:0] timeout_limit_i,
   output logic [NUM_CORES-1:0]     core_stall_o,
   output logic [NUM_CORES-1:0]     core_release_o,
   output logic [NUM_CORES-1:0]     active_mask_o,
   output logic                     busy_o,
   output logic                     all_done_o,
   output logic [CountWidth-1:0]    barrier_count_o,
   output logic                     timeout_err_o
);

   barrier_state_e          state_q, state_d;
   logic [NUM_CORES-1:0]    active_q, active_d;
   logic [NUM_CORES-1:0]    arrived_q, arrived_d;
   logic [CountWidth-1:0]   count_q, count_d;

   logic [NUM_CORES-1:0]    active_next;
   logic [NUM_CORES-1:0]    arrived_next;
   logic                    complete;
   logic                    wd_start, wd_clear, wd_inc;

   always_comb begin
      // Exit masks the same-cycle request of that core before the completion test.
      active_next  = active_q & ~core_exit_i;
      arrived_next = (arrived_q | core_sync_req_i) & active_next;
      complete     = (arrived_next == active_next) && (arrived_next != '0);

      state_d   = state_q;
      active_d  = active_q;
      arrived_d = arrived_q;
      count_d   = count_q;
      wd_start  = 1'b0;
      wd_clear  = 1'b0;
      wd_inc    = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d   = StRun;
               active_d  = '1;
               arrived_d = '0;
               count_d   = '0;
               wd_start  = 1'b1;
            end
         end
         StRun: begin
            active_d = active_next;
            if (active_next == '0) begin
               state_d   = StDone;
               arrived_d = '0;
            end else if (complete) begin
               state_d   = StRelease;
               arrived_d = arrived_next;
               wd_clear  = 1'b1;
            end else begin
               arrived_d = arrived_next;
               wd_inc    = (arrived_q != '0);
            end
         end
         StRelease: begin
            count_d   = count_q + 1'b1;
            arrived_d = '0;
            active_d  = active_next;
            state_d   = (active_next == '0) ? StDone : StRun;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         active_q  <= '0;
         arrived_q <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         arrived_q <= arrived_d;
         count_q   <= count_d;
      end
   end

   barrier_watchdog #(
      .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .start_i(wd_start),
      .clear_i(wd_clear),
      .inc_i  (wd_inc),
      .limit_i(timeout_limit_i),
      .err_o  (timeout_err_o)
   );

   always_comb begin
      core_release_o  = (state_q == StRelease) ? arrived_q : '0;
      core_stall_o    = active_q & core_sync_req_i & ~core_release_o;
      active_mask_o   = active_q;
      busy_o          = (state_q == StRun) || (state_q == StRelease);
      all_done_o      = (state_q == StDone);
      barrier_count_o = count_q;
   end

endmodule

// File: tb/tb_barrier_controller.sv
// Directed-vector bench for barrier_controller with hand-computed expectations.
module tb_barrier_controller;

   localparam int unsigned N  = 4;
   localparam int unsigned TW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [N-1:0]  sync_req, core_exit;
   logic [TW-1:0] limit;
   logic [N-1:0]  stall, release_w, active;
   logic          busy, all_done, terr;
   logic [7:0]    count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   barrier_controller #(
      .NUM_CORES    (N),
      .TIMEOUT_WIDTH(TW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start),
      .core_sync_req_i(sync_req),
      .core_exit_i    (core_exit),
      .timeout_limit_i(limit),
      .core_stall_o   (stall),
      .core_release_o (release_w),
      .active_mask_o  (active),
      .busy_o         (busy),
      .all_done_o     (all_done),
      .barrier_count_o(count),
      .timeout_err_o  (terr)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sync_req = '0; core_exit = '0; limit = '0;
      #2;
      check_eq("rst_stall", {28'd0, stall}, 32'h0);
      check_eq("rst_active", {28'd0, active}, 32'h0);
      check_eq("rst_flags", {28'd0, busy, all_done, terr, |release_w}, 32'h0);
      check_eq("rst_count", {24'd0, count}, 32'h0);
      step(); step();
      rst = 1'b0;
      step();

      // 1: staggered arrivals
      start = 1'b1; step(); start = 1'b0; #1;
      check_eq("t1_active", {28'd0, active}, 32'hF);
      check_eq("t1_busy", {31'd0, busy}, 32'h1);
      sync_req = 4'b0001; #1;
      check_eq("t1_stall_a", {28'd0, stall}, 32'h1);
      step();
      sync_req = 4'b0011; #1;
      check_eq("t1_stall_b", {28'd0, stall}, 32'h3);
      check_eq("t1_norel_b", {28'd0, release_w}, 32'h0);
      step();
      sync_req = 4'b1111; #1;
      check_eq("t1_stall_c", {28'd0, stall}, 32'hF);
      check_eq("t1_norel_c", {28'd0, release_w}, 32'h0);
      step(); #1;
      check_eq("t1_release", {28'd0, release_w}, 32'hF);
      check_eq("t1_stall_rel", {28'd0, stall}, 32'h0);
      check_eq("t1_busy_rel", {31'd0, busy}, 32'h1);
      step();
      sync_req = '0; #1;
      check_eq("t1_rel_once", {28'd0, release_w}, 32'h0);
      check_eq("t1_count", {24'd0, count}, 32'h1);
      check_eq("t1_noterr", {31'd0, terr}, 32'h0);

      // 3: all cores exit
      core_exit = 4'b0001; step();
      core_exit = 4'b0010; step(); #1;
      check_eq("t3_active", {28'd0, active}, 32'hC);
      core_exit = 4'b1100; step();
      core_exit = '0; #1;
      check_eq("t3_done", {31'd0, all_done}, 32'h1);
      check_eq("t3_busy", {31'd0, busy}, 32'h0);
      check_eq("t3_mask", {28'd0, active}, 32'h0);
      start = 1'b1; step(); start = 1'b0; #1;
      check_eq("t3_restart_mask", {28'd0, active}, 32'hF);
      check_eq("t3_restart_cnt", {24'd0, count}, 32'h0);
      check_eq("t3_restart_done", {31'd0, all_done}, 32'h0);

      // 2: exit of the last straggler completes the barrier
      sync_req = 4'b0111; step();
      #1;
      check_eq("t2_stall", {28'd0, stall}, 32'h7);
      core_exit = 4'b1000; #1;
      check_eq("t2_norel", {28'd0, release_w}, 32'h0);
      step();
      core_exit = '0; #1;
      check_eq("t2_release", {28'd0, release_w}, 32'h7);
      check_eq("t2_active", {28'd0, active}, 32'h7);
      step();
      sync_req = '0; #1;
      check_eq("t2_count", {24'd0, count}, 32'h1);
      core_exit = 4'b0111; step();
      core_exit = '0; #1;
      check_eq("t2_done", {31'd0, all_done}, 32'h1);
      start = 1'b1; step(); start = 1'b0;

      // 4: same-cycle sync and exit on core 2
      sync_req = 4'b1011; step();
      sync_req = 4'b1111; core_exit = 4'b0100; step();
      sync_req = 4'b1011; core_exit = '0; #1;
      check_eq("t4_release", {28'd0, release_w}, 32'hB);
      check_eq("t4_active", {28'd0, active}, 32'hB);
      check_eq("t4_stall", {28'd0, stall}, 32'h0);
      step();
      sync_req = '0; #1;
      check_eq("t4_count", {24'd0, count}, 32'h1);

      // 5: watchdog; active=1011
      limit = 16'd10;
      sync_req = 4'b0001; step();
      for (int i = 0; i < 10; i++) step();
      #1;
      check_eq("t5_err_early", {31'd0, terr}, 32'h0);
      check_eq("t5_waiting", {28'd0, stall}, 32'h1);
      step(); #1;
      check_eq("t5_err_set", {31'd0, terr}, 32'h1);
      for (int i = 0; i < 5; i++) step();
      #1;
      check_eq("t5_err_sticky", {31'd0, terr}, 32'h1);
      sync_req = 4'b1011; step(); #1;
      check_eq("t5_release", {28'd0, release_w}, 32'hB);
      step();
      sync_req = '0; #1;
      check_eq("t5_count", {24'd0, count}, 32'h2);
      check_eq("t5_err_kept", {31'd0, terr}, 32'h1);
      core_exit = 4'b1011; step();
      core_exit = '0; #1;
      check_eq("t5_done_err", {31'd0, terr}, 32'h1);
      start = 1'b1; step(); start = 1'b0; #1;
      check_eq("t5_err_clr", {31'd0, terr}, 32'h0);

      // 6: reset mid-barrier
      sync_req = 4'b0011; step();
      #2;
      rst = 1'b1; #1;
      check_eq("t6_stall", {28'd0, stall}, 32'h0);
      check_eq("t6_active", {28'd0, active}, 32'h0);
      check_eq("t6_flags", {28'd0, busy, all_done, terr, |release_w}, 32'h0);
      sync_req = 4'b1111;
      step(); rst = 1'b0;
      step(); #1;
      check_eq("t6_norel", {28'd0, release_w}, 32'h0);
      check_eq("t6_idle", {28'd0, busy, all_done, |active, 1'b0}, 32'h0);
      sync_req = '0;
      start = 1'b1; step(); start = 1'b0; #1;
      check_eq("t6_resume", {28'd0, active}, 32'hF);
      check_eq("t6_resume_busy", {31'd0, busy}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
